// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the default address width and reset PC, the RV32I opcode constants
// used around the fetch/decode boundary, the canonical NOP, the fetch-entry
// record type and a small opcode-extraction helper.
package instr_fetch_unit_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0]  OP_RTYPE = 7'b0110011;
  localparam logic [6:0]  OP_ITYPE = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

  function automatic logic [6:0] opcodeOf(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small register-based synchronous FIFO used twice by the fetch unit
// (PC-tag queue and instruction buffer).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, pushData      write request and data
//   pop                 remove head (ignored when empty)
//   flush               empty the FIFO; same-cycle push/pop are ignored
//   popData             current head (combinational, valid when !empty)
//   count, full, empty  occupancy status
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           popData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] countQ;
  logic             doPush, doPop;

  // Per-entry registers; the head must be visible in the same cycle it is
  // written back to decode, so storage is flops rather than a RAM.
  wire  [DEPTH-1:0][WIDTH-1:0] entries;

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign empty   = (countQ == '0);
  assign full    = (countQ == CNT_W'(DEPTH));
  assign count   = countQ;
  assign doPop   = pop && !flush && !empty;
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign doPush  = push && !flush && (!full || doPop);
  assign popData = entries[rdPtr];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [WIDTH-1:0] entryQ;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entryQ <= '0;
        end else if (doPush && (wrPtr == PTR_W'(gi))) begin
          entryQ <= pushData;
        end
      end
      assign entries[gi] = entryQ;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else if (flush) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtr <= incPtr(wrPtr);
      if (doPop)  rdPtr <= incPtr(rdPtr);
      unique case ({doPush, doPop})
        2'b10:   countQ <= countQ + CNT_W'(1);
        2'b01:   countQ <= countQ - CNT_W'(1);
        default: countQ <= countQ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Upstream credit accounting must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !flush && full && !doPop))
        else $error("fetch_fifo overflow");
    end
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word requests to instruction
// memory, buffers returned words with their PCs and presents them to decode.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request channel (addr = word-aligned PC)
//   imem_rsp_valid/data          in-order responses, >= 1 cycle after acceptance
//   redirect_valid/pc            one-cycle PC redirect from branch/jump resolution
//   if_valid/ready               decode handshake
//   if_pc/instr/opcode           presented entry; opcode feeds the controller
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = XLEN + 32;

  logic [XLEN-1:0]    pcQ, pcNext;
  logic [CNT_W-1:0]   inflightQ, inflightNext;
  logic [CNT_W-1:0]   dropQ, dropNext;
  logic               runQ;

  logic               reqFire, hasCredit, rspKeep;
  logic [XLEN-1:0]    rspPc;
  logic [ENTRY_W-1:0] bufHead;
  logic [CNT_W-1:0]   bufCount, tagCount;
  logic               bufFull, bufEmpty, tagFull, tagEmpty;
  logic               unusedSigs;

  // Requests in flight plus buffered words may never exceed DEPTH, which is
  // what keeps the instruction buffer from overflowing.
  assign hasCredit      = ({1'b0, inflightQ} + {1'b0, bufCount}) < (CNT_W + 1)'(DEPTH);
  // runQ holds off the first request until the first edge after reset release,
  // so the request is low for the whole reset period.
  assign imem_req_valid = runQ && hasCredit && !redirect_valid;
  assign imem_req_addr  = pcQ;
  assign reqFire        = imem_req_valid && imem_req_ready;
  assign rspKeep        = imem_rsp_valid && (dropQ == '0) && !redirect_valid;

  // PC tag for every accepted request; popped by every response, dropped or
  // not, so it always lines up with the in-order response stream.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) uTagQueue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (reqFire),
    .pushData (pcQ),
    .pop      (imem_rsp_valid),
    .flush    (1'b0),
    .popData  (rspPc),
    .count    (tagCount),
    .full     (tagFull),
    .empty    (tagEmpty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) uInstrBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rspKeep),
    .pushData ({rspPc, imem_rsp_data}),
    .pop      (if_valid && if_ready),
    .flush    (redirect_valid),
    .popData  (bufHead),
    .count    (bufCount),
    .full     (bufFull),
    .empty    (bufEmpty)
  );

  always_comb begin
    pcNext       = pcQ;
    inflightNext = inflightQ;
    dropNext     = dropQ;

    unique case ({reqFire, imem_rsp_valid})
      2'b10:   inflightNext = inflightQ + CNT_W'(1);
      2'b01:   inflightNext = inflightQ - CNT_W'(1);
      default: inflightNext = inflightQ;
    endcase

    if (redirect_valid) begin
      pcNext   = {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still outstanding after this cycle belongs to the old path;
      // a response arriving now is already discarded and is not counted.
      dropNext = inflightNext;
    end else begin
      if (reqFire) pcNext = pcQ + XLEN'(4);
      if (imem_rsp_valid && (dropQ != '0)) dropNext = dropQ - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ       <= RESET_PC;
      inflightQ <= '0;
      dropQ     <= '0;
      runQ      <= 1'b0;
    end else begin
      pcQ       <= pcNext;
      inflightQ <= inflightNext;
      dropQ     <= dropNext;
      runQ      <= 1'b1;
    end
  end

  // Outputs read zero whenever nothing is presented.
  assign if_valid  = !bufEmpty;
  assign if_pc     = if_valid ? bufHead[ENTRY_W-1:32] : '0;
  assign if_instr  = if_valid ? bufHead[31:0] : '0;
  assign if_opcode = opcodeOf(if_instr);

  assign unusedSigs = &{1'b0, redirect_pc[1:0], tagCount, tagFull, tagEmpty, bufFull};

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [6:0]  if_opcode;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } memReq_t;
  memReq_t memQ[$];

  int checks = 0, errors = 0, cyc = 0;
  int acceptCnt = 0, deliverCnt = 0;
  logic [31:0] expPc, expReqPc, lastAcceptAddr, lastDeliveredPc, prevAddr;
  logic [6:0]  lastDeliveredOp;
  bit          prevStall;
  bit          obsReqValid, obsIfValid, obsRsp;
  logic [31:0] obsAddr, obsIfPc;

  // Memory contents: a fixed word at 0, otherwise an address-derived word whose
  // opcode rotates through the four package opcodes.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h0) return 32'h0050_0093;
    case (a[3:2])
      2'd0:    op = OP_RTYPE;
      2'd1:    op = OP_ITYPE;
      2'd2:    op = OP_LOAD;
      default: op = OP_STORE;
    endcase
    return {a[26:2] ^ 25'h1A5A5A5, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    memQ.delete();
    expPc = RST_PC; expReqPc = RST_PC; prevStall = 1'b0;
    acceptCnt = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_opcode", 32'(if_opcode), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later,
  // update the reference model with what will happen at the next rising edge.
  task automatic step(input bit rdy, input bit ifr, input bit redir,
                      input logic [31:0] rpc, input int lat, input bit rspEn);
    logic [31:0] w;
    @(negedge clk);
    imem_req_ready = rdy; if_ready = ifr;
    redirect_valid = redir; redirect_pc = rpc;
    obsRsp = rspEn && (memQ.size() > 0) && (memQ[0].due <= cyc);
    imem_rsp_valid = obsRsp;
    imem_rsp_data  = obsRsp ? memWord(memQ[0].addr) : 32'h0;
    #1;
    obsReqValid = imem_req_valid; obsAddr = imem_req_addr;
    obsIfValid = if_valid; obsIfPc = if_pc;
    if (redir) chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
    if (prevStall && !redir) begin
      chk("stall_valid_held", 32'(imem_req_valid), 32'd1);
      chk("stall_addr_held", imem_req_addr, prevAddr);
    end
    if (if_valid) begin
      w = memWord(expPc);
      chk("if_pc", if_pc, expPc);
      chk("if_instr", if_instr, w);
      chk("if_opcode", 32'(if_opcode), 32'(w[6:0]));
    end
    if (obsRsp) void'(memQ.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, expReqPc);
      memQ.push_back('{addr: imem_req_addr, due: cyc + lat});
      chk("outstanding_le_depth", 32'(memQ.size() <= DEPTH), 32'd1);
      lastAcceptAddr = imem_req_addr;
      acceptCnt++;
      expReqPc = expReqPc + 32'd4;
    end
    if (if_valid && if_ready && !redir) begin
      lastDeliveredPc = if_pc; lastDeliveredOp = if_opcode;
      expPc = expPc + 32'd4;
      deliverCnt++;
    end
    prevStall = imem_req_valid && !imem_req_ready;
    prevAddr  = imem_req_addr;
    if (redir) begin
      expPc = {rpc[31:2], 2'b00}; expReqPc = {rpc[31:2], 2'b00}; prevStall = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    int base, seen, n;
    logic [6:0] firstOp;

    // 1: streaming with everything ready, latency 1
    doReset();
    base = deliverCnt; firstOp = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 32'h0, 1, 1);
      if (deliverCnt == base + 1 && i < 12) firstOp = lastDeliveredOp;
      if (deliverCnt > base + 1 && firstOp == '0) firstOp = 7'h7F;
    end
    $display("T1 stream: delivered %0d last pc %h", deliverCnt - base, lastDeliveredPc);
    chk("t1_delivered", 32'(deliverCnt - base >= 3), 32'd1);
    chk("t1_first_opcode", 32'(firstOp), 32'(OP_ITYPE));

    // 2: decode stalled -> exactly two requests, then resume in order
    doReset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 1, 1);
    $display("T2 stall: accepts %0d if_pc %h", acceptCnt, obsIfPc);
    chk("t2_accept_cnt", 32'(acceptCnt), 32'd2);
    chk("t2_req_valid", 32'(obsReqValid), 32'd0);
    chk("t2_if_valid", 32'(obsIfValid), 32'd1);
    chk("t2_if_pc", obsIfPc, 32'h0);
    base = deliverCnt;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0, 1, 1);
    $display("T2 resume: delivered %0d accepts %0d", deliverCnt - base, acceptCnt);
    chk("t2_resume_delivered", 32'(deliverCnt - base >= 3), 32'd1);
    chk("t2_resume_accepts", 32'(acceptCnt >= 3), 32'd1);

    // 3: memory not ready for three offered cycles at 0x8
    doReset();
    n = 0;
    while (acceptCnt < 2 && n < 20) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t3_setup_accepts", 32'(acceptCnt), 32'd2);
    seen = 0; n = 0;
    while (seen < 3 && n < 30) begin
      step(0, 1, 0, 32'h0, 1, 1); n++;
      if (obsReqValid) begin chk("t3_stall_addr", obsAddr, 32'h8); seen++; end
    end
    chk("t3_stall_cycles", 32'(seen), 32'd3);
    n = 0;
    while (acceptCnt < 3 && n < 20) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t3_accept_8", lastAcceptAddr, 32'h8);
    n = 0;
    while (acceptCnt < 4 && n < 20) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t3_next_c", lastAcceptAddr, 32'hC);
    $display("T3 stall: held %0d cycles, last accept %h", seen, lastAcceptAddr);

    // 4: redirect with two requests in flight
    doReset();
    step(1, 0, 0, 32'h0, 5, 1);
    step(1, 0, 0, 32'h0, 5, 1);
    chk("t4_inflight", 32'(acceptCnt), 32'd2);
    step(1, 0, 1, 32'h102, 1, 1);
    base = deliverCnt; n = 0;
    while (acceptCnt < 3 && n < 30) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t4_new_addr", lastAcceptAddr, 32'h100);
    n = 0;
    while (deliverCnt == base && n < 30) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t4_first_pc", lastDeliveredPc, 32'h100);
    $display("T4 redirect: first req %h first pc %h", 32'h100, lastDeliveredPc);

    // 5: redirect coinciding with a response and a decode handshake
    doReset();
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 3, 1);
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 1, 1);
    base = deliverCnt;
    step(1, 1, 1, 32'h200, 1, 1);
    chk("t5_setup_rsp", 32'(obsRsp), 32'd1);
    chk("t5_setup_if_valid", 32'(obsIfValid), 32'd1);
    step(0, 0, 0, 32'h0, 1, 1);
    chk("t5_flushed", 32'(obsIfValid), 32'd0);
    n = 0;
    while (deliverCnt == base && n < 30) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t5_first_pc", lastDeliveredPc, 32'h200);
    $display("T5 redirect+rsp+pop: first pc %h", lastDeliveredPc);

    // 6: asynchronous reset mid-cycle
    doReset();
    step(1, 0, 0, 32'h0, 1, 1);
    step(1, 0, 0, 32'h0, 5, 1);
    @(posedge clk);
    #2;
    chk("t6_setup_if_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_if_valid", 32'(if_valid), 32'd0);
    chk("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    doReset();
    n = 0;
    while (acceptCnt < 1 && n < 10) begin step(1, 1, 0, 32'h0, 1, 1); n++; end
    chk("t6_first_req", lastAcceptAddr, RST_PC);
    $display("T6 async reset: first req %h", lastAcceptAddr);

    // 7: randomized traffic against the reference model
    doReset();
    base = deliverCnt;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : 32'($urandom_range(0, 1023));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, rpc,
           int'($urandom_range(1, 4)), $urandom_range(0, 3) != 0);
    end
    $display("T7 random: delivered %0d", deliverCnt - base);
    chk("t7_progress", 32'(deliverCnt - base >= 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
